// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data memory controller.
// Holds the access-size encodings, the controller state encoding and the
// default byte address of RAM word 0. No ports; imported by the controller
// top and the lane alignment sub-module.
package mem_ctrl_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } req_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for 32-bit little-endian words.
// Ports:
//   rd_word     in  32  word currently read from RAM
//   wdata       in  32  right-justified store data
//   size        in   2  access size (byte / half / word)
//   byte_sel    in   2  byte offset inside the word
//   is_signed   in   1  sign-extend extracted loads
//   merged_word out 32  rd_word with the selected lanes replaced by wdata
//   load_data   out 32  selected lanes extracted and extended
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  req_size_e   size,
  input  logic [1:0]  byte_sel,
  input  logic        is_signed,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [4:0]  lane_shift_s;
  logic [31:0] lane_mask_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Bit position of the addressed lane (byte_sel * 8).
  assign lane_shift_s = {byte_sel, 3'b000};

  // Build the mask of lanes a store overwrites; illegal size touches nothing.
  always_comb begin
    case (size)
      SIZE_BYTE: lane_mask_s = 32'h0000_00FF << lane_shift_s;
      SIZE_HALF: lane_mask_s = 32'h0000_FFFF << lane_shift_s;
      SIZE_WORD: lane_mask_s = 32'hFFFF_FFFF;
      default:   lane_mask_s = 32'h0000_0000;
    endcase
  end

  // Store data is shifted into the addressed lanes; other lanes keep rd_word.
  assign merged_word = (rd_word & ~lane_mask_s) | ((wdata << lane_shift_s) & lane_mask_s);

  // Pick the addressed byte lane.
  always_comb begin
    case (byte_sel)
      2'd0:    byte_s = rd_word[7:0];
      2'd1:    byte_s = rd_word[15:8];
      2'd2:    byte_s = rd_word[23:16];
      2'd3:    byte_s = rd_word[31:24];
      default: byte_s = rd_word[7:0];
    endcase
  end

  // Halfwords are always aligned, so only byte_sel[1] selects the half.
  assign half_s = byte_sel[1] ? rd_word[31:16] : rd_word[15:0];

  // Extend the extracted lane to a full word.
  always_comb begin
    case (size)
      SIZE_BYTE: load_data = {{24{is_signed & byte_s[7]}}, byte_s};
      SIZE_HALF: load_data = {{16{is_signed & half_s[15]}}, half_s};
      SIZE_WORD: load_data = rd_word;
      default:   load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Load/store controller in front of a single-port word RAM.
// Accepts one byte/half/word request at a time, range- and alignment-checks
// it, performs read-modify-write for sub-word stores and returns a one-cycle
// response pulse.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready, req_write, req_size, req_signed, req_address, req_wdata
//   rsp_valid, rsp_rdata, rsp_error
//   ram_write_enable, ram_address, ram_WriteData, ram_ReadData (to single_port_ram)
module data_memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  ram_write_enable,
  output logic [31:0]           ram_address,
  output logic [DATA_WIDTH-1:0] ram_WriteData,
  input  logic [DATA_WIDTH-1:0] ram_ReadData
);

  localparam logic [31:0] BYTE_SPAN = 32'(MEMORY_DEPTH * 4);

  ctrl_state_e state_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_error_r;
  logic        ram_we_r;
  logic [31:0] ram_address_r;
  logic [31:0] ram_wdata_r;

  logic        write_r;
  req_size_e   size_r;
  logic        signed_r;
  logic [1:0]  byte_sel_r;
  logic [31:0] wdata_r;

  logic [31:0] offset_s;
  logic        in_range_s;
  logic        req_error_s;
  logic        accept_s;
  logic [31:0] word_address_s;
  logic [31:0] merged_s;
  logic [31:0] load_s;

  assign accept_s       = req_valid & req_ready_r;
  assign offset_s       = req_address - BASE_ADDRESS;
  // Both tests are needed: the subtraction wraps for addresses below the base.
  assign in_range_s     = (req_address >= BASE_ADDRESS) && (offset_s < BYTE_SPAN);
  assign word_address_s = BASE_ADDRESS + {offset_s[31:2], 2'b00};

  // Classify the incoming request as rejected or serviceable.
  always_comb begin
    req_error_s = 1'b0;
    if (!in_range_s) begin
      req_error_s = 1'b1;
    end else begin
      case (req_size)
        SIZE_BYTE: req_error_s = 1'b0;
        SIZE_HALF: req_error_s = offset_s[0];
        SIZE_WORD: req_error_s = (offset_s[1:0] != 2'b00);
        default:   req_error_s = 1'b1;
      endcase
    end
  end

  mem_lane_align u_lane_align (
    .rd_word     (ram_ReadData),
    .wdata       (wdata_r),
    .size        (size_r),
    .byte_sel    (byte_sel_r),
    .is_signed   (signed_r),
    .merged_word (merged_s),
    .load_data   (load_s)
  );

  // Controller FSM; every output is a register updated on state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_error_r   <= 1'b0;
      ram_we_r      <= 1'b0;
      ram_address_r <= BASE_ADDRESS;
      ram_wdata_r   <= 32'h0000_0000;
      write_r       <= 1'b0;
      size_r        <= SIZE_BYTE;
      signed_r      <= 1'b0;
      byte_sel_r    <= 2'b00;
      wdata_r       <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            write_r     <= req_write;
            size_r      <= req_size_e'(req_size);
            signed_r    <= req_signed;
            byte_sel_r  <= offset_s[1:0];
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            if (req_error_s) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_error_r <= 1'b1;
              rsp_rdata_r <= 32'h0000_0000;
            end else begin
              ram_address_r <= word_address_s;
              // Full-word stores need no read; go straight to the write.
              if (req_write && (req_size == SIZE_WORD)) begin
                state_r     <= ST_WRITE;
                ram_we_r    <= 1'b1;
                ram_wdata_r <= req_wdata;
              end else begin
                state_r <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (write_r) begin
            state_r     <= ST_WRITE;
            ram_we_r    <= 1'b1;
            ram_wdata_r <= merged_s;
          end else begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= 1'b0;
            rsp_rdata_r <= load_s;
          end
        end
        ST_WRITE: begin
          state_r     <= ST_RESP;
          ram_we_r    <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_error_r <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          ram_we_r    <= 1'b0;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_r;
  assign rsp_valid        = rsp_valid_r;
  assign rsp_rdata        = rsp_rdata_r;
  assign rsp_error        = rsp_error_r;
  assign ram_write_enable = ram_we_r;
  assign ram_address      = ram_address_r;
  assign ram_WriteData    = ram_wdata_r;

endmodule

// File: doc/data_memory_controller.md
DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, RAM depth in words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 supported.
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h10010000, byte address of RAM word 0.
REQ-004 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: req_valid in 1, request present; req_ready out 1, controller accepts.
REQ-007 SHALL have ports: req_write in 1, 1=store 0=load; req_size in 2, 00 byte, 01 half, 10 word, 11 illegal; req_signed in 1, sign-extend loads.
REQ-008 SHALL have ports: req_address in 32, byte address; req_wdata in 32, store data, right-justified.
REQ-009 SHALL have ports: rsp_valid out 1, one-cycle completion pulse; rsp_rdata out 32, load result; rsp_error out 1, request rejected.
REQ-010 SHALL have ports: ram_write_enable out 1; ram_address out 32; ram_WriteData out 32; ram_ReadData in 32; these connect to single_port_ram.

Function
REQ-011 SHALL implement states IDLE, READ, WRITE, RESP.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid and req_ready both high, and all request fields are registered then.
REQ-013 SHALL compute offset = req_address - BASE_ADDRESS (32-bit, wrapping); in range iff offset < MEMORY_DEPTH*4 and req_address >= BASE_ADDRESS.
REQ-014 SHALL flag error when out of range, req_size=11, half with offset[0]=1, or word with offset[1:0]!=0.
REQ-015 SHALL transition on accept: error -> RESP; load -> READ; word store -> WRITE; byte/half store -> READ.
REQ-016 SHALL drive ram_address = BASE_ADDRESS + {offset[31:2],2'b00} in READ and WRITE; hold last value otherwise.
REQ-017 SHALL treat ram_ReadData as valid in the same cycle as ram_address and capture it at the end of READ.
REQ-018 SHALL go READ -> RESP for loads and READ -> WRITE for sub-word stores.
REQ-019 SHALL, in WRITE, pulse ram_write_enable for exactly one cycle with ram_WriteData = captured word with selected lanes replaced (little-endian: byte k at bits 8k+7:8k); word store uses req_wdata directly; then go to RESP.
REQ-020 SHALL, in RESP, assert rsp_valid for one cycle, then return to IDLE; no backpressure on response.
REQ-021 SHALL return loads as: byte/half lane extracted, zero- or sign-extended per req_signed; word unchanged; rsp_rdata=0 on stores and errors.
REQ-022 SHALL never assert ram_write_enable for an errored request.
REQ-023 SHALL meet latency from accept edge to rsp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-024 SHALL hold rsp_rdata and rsp_error stable until the next RESP.

Reset
REQ-025 SHALL, on reset low, immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, ram_write_enable=0, ram_address=BASE_ADDRESS, ram_WriteData=0.
REQ-026 SHALL abandon any in-flight request on reset, including mid read-modify-write, with no RAM write and no response.

Structure
REQ-027 SHALL place size encodings, state encoding, and BASE_ADDRESS default in shared package mem_ctrl_pkg.
REQ-028 SHALL put lane merge/extract logic in a combinational sub-module mem_lane_align.

Verification
REQ-029 SHALL verify word store 0x12345678 @0x10010008, then word load @0x10010008 -> rsp_rdata=0x12345678, error=0, latency 2.
REQ-030 SHALL verify byte store 0xAB @0x10010009 over 0x12345678, then word load -> 0x1234AB78; signed byte load @0x10010009 -> 0xFFFFFFAB.
REQ-031 SHALL verify half store 0xBEEF @0x10010016 over 0xABCDEF12 -> word 0xBEEFEF12; unsigned half load -> 0x0000BEEF.
REQ-032 SHALL verify word load @0x1001000A and any access @0x10010080 (depth 32) -> rsp_error=1 after 1 cycle, ram_write_enable never high.
REQ-033 SHALL verify reset asserted in WRITE of a byte store -> target word unchanged, rsp_valid stays 0, req_ready=1 after release.
REQ-034 SHALL verify back-to-back requests with req_valid held high -> req_ready low READ through RESP; second request accepted only in IDLE.
